// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the UART memory loader.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CHK,
        DONE
    } state_e;

    localparam logic [7:0] HDR_DONE  = 8'hFF;
    localparam logic [7:0] HDR_REARM = 8'hFE;

    // Wide enough for the largest legal NumMems; callers slice it down.
    function automatic logic [255:0] onehot(input int unsigned idx, input int unsigned n);
        logic [255:0] res;
        res = '0;
        if (idx < n && idx < 256) res[idx[7:0]] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and memory-write output bundle of the loader.
interface mem_loader_if #(
    parameter int NumMems   = 2,
    parameter int AddrWidth = 12,
    parameter int DataWidth = 32
);
    logic                 rx_dv_i;
    logic [7:0]           rx_byte_i;
    logic                 we_o;
    logic [NumMems-1:0]   sel_o;
    logic [AddrWidth-1:0] addr_o;
    logic [DataWidth-1:0] wdata_o;
    logic                 reset_o;
    logic                 busy_o;
    logic                 err_o;

    modport master (
        input  rx_dv_i, rx_byte_i,
        output we_o, sel_o, addr_o, wdata_o, reset_o, busy_o, err_o
    );

    modport slave (
        output rx_dv_i, rx_byte_i,
        input  we_o, sel_o, addr_o, wdata_o, reset_o, busy_o, err_o
    );
endinterface

// File: rtl/mem_loader_word_asm.sv
// Little-endian word assembler: shifts bytes in LSB first, flags the final byte of each word.
module mem_loader_word_asm #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_i,
    output logic                 word_done_o,
    output logic [DataWidth-1:0] word_o
);
    localparam int NumBytes = DataWidth / 8;
    localparam int CntWidth = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(NumBytes - 1);

    logic [CntWidth-1:0]  cnt_q;
    logic [DataWidth-1:0] shift_q, shift_d;

    generate
        if (NumBytes == 1) begin : g_single
            assign shift_d = byte_i;
        end else begin : g_multi
            assign shift_d = {byte_i, shift_q[DataWidth-1:8]};
        end
    endgenerate

    // The completed word is presented combinationally so the top can register it on the same edge.
    assign word_o      = shift_d;
    assign word_done_o = byte_valid_i && (cnt_q == CntLast);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            shift_q <= shift_d;
            cnt_q   <= word_done_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// UART stream loader: parses sections and writes words into one of NumMems memories.
// Define LOADER_CHECKSUM_EN to add a per-section XOR checksum byte (CHK state).
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int NumMems       = 2,
    parameter int AddrWidth     = 12,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 1000000
) (
    input logic         clk_i,
    input logic         rst_ni,
    mem_loader_if.master bus
);
    localparam logic [31:0] TmoLast   = (TimeoutCycles > 0) ? 32'(TimeoutCycles - 1) : 32'd0;
    localparam logic [8:0]  NumMemsW  = 9'(NumMems);

    state_e               state_q, state_d;
    logic [7:0]           target_q, cnt_lo_q;
    logic [15:0]          remaining_q, word_idx_q;
    logic [31:0]          tmo_q;
    logic                 err_q, we_q;
    logic [NumMems-1:0]   sel_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q, word;
    logic                 active, timeout, word_done, overflow, valid_hdr;
    logic [15:0]          count_full;
    logic [255:0]         target_onehot;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum_q;
`endif

    assign active        = state_q inside {CNT_LO, CNT_HI, DATA, CHK};
    assign timeout       = (TimeoutCycles != 0) && active && !bus.rx_dv_i && (tmo_q == TmoLast);
    assign count_full    = {bus.rx_byte_i, cnt_lo_q};
    assign valid_hdr     = {1'b0, bus.rx_byte_i} < NumMemsW;
    // Word indices past the memory depth are still counted so the stream stays framed.
    assign overflow      = (32'(word_idx_q) >> AddrWidth) != 32'd0;
    assign target_onehot = onehot(32'(target_q), NumMems);

    mem_loader_word_asm #(.DataWidth(DataWidth)) u_word_asm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (timeout || state_q != DATA),
        .byte_valid_i (bus.rx_dv_i && state_q == DATA),
        .byte_i       (bus.rx_byte_i),
        .word_done_o  (word_done),
        .word_o       (word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (bus.rx_dv_i) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.rx_byte_i == HDR_DONE) state_d = DONE;
                    else if (valid_hdr)            state_d = CNT_LO;
                end
                CNT_LO: state_d = CNT_HI;
                CNT_HI: state_d = (count_full == 16'd0) ? IDLE : DATA;
                DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    if (word_done && remaining_q == 16'd1) state_d = CHK;
`else
                    if (word_done && remaining_q == 16'd1) state_d = IDLE;
`endif
                end
                CHK:  state_d = IDLE;
                DONE: if (bus.rx_byte_i == HDR_REARM) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.reset_o = (state_q != DONE);
        bus.busy_o  = active;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target_q    <= '0;
            cnt_lo_q    <= '0;
            remaining_q <= '0;
            word_idx_q  <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            we_q  <= 1'b0;
            sel_q <= '0;
            tmo_q <= (!active || bus.rx_dv_i) ? 32'd0 : tmo_q + 32'd1;
            if (timeout) err_q <= 1'b1;
            if (bus.rx_dv_i) begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.rx_byte_i == HDR_DONE) begin
                            // Enter DONE; nothing to latch.
                        end else if (valid_hdr) begin
                            target_q <= bus.rx_byte_i;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    CNT_LO: cnt_lo_q <= bus.rx_byte_i;
                    CNT_HI: begin
                        remaining_q <= count_full;
                        word_idx_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q      <= '0;
`endif
                    end
                    DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.rx_byte_i;
`endif
                        if (word_done) begin
                            remaining_q <= remaining_q - 16'd1;
                            word_idx_q  <= word_idx_q + 16'd1;
                            if (overflow) begin
                                err_q <= 1'b1;
                            end else begin
                                we_q    <= 1'b1;
                                sel_q   <= target_onehot[NumMems-1:0];
                                addr_q  <= AddrWidth'(word_idx_q);
                                wdata_q <= word;
                            end
                        end
                    end
                    CHK: begin
`ifdef LOADER_CHECKSUM_EN
                        if (bus.rx_byte_i != csum_q) err_q <= 1'b1;
`endif
                    end
                    DONE: if (bus.rx_byte_i == HDR_REARM) err_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign bus.we_o    = we_q;
    assign bus.sel_o   = sel_q;
    assign bus.addr_o  = addr_q;
    assign bus.wdata_o = wdata_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed scenarios plus randomized sections vs. a section-level model.
module tb_mem_loader;
    localparam int NumMems       = 2;
    localparam int AddrWidth     = 2;
    localparam int DataWidth     = 32;
    localparam int TimeoutCycles = 100;
    localparam int Depth         = 1 << AddrWidth;
`ifdef LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    typedef struct packed {
        logic [NumMems-1:0]   sel;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
    } wr_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   sel_glitches = 0;
    bit   exp_err = 1'b0;
    wr_t  act_q[$];
    wr_t  exp_q[$];
    logic [7:0] payload[$];

    mem_loader_if #(.NumMems(NumMems), .AddrWidth(AddrWidth), .DataWidth(DataWidth)) bus ();

    mem_loader #(
        .NumMems(NumMems), .AddrWidth(AddrWidth),
        .DataWidth(DataWidth), .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Write monitor: records every strobe; sel must be idle-zero whenever we_o is low.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus.we_o) begin
                wr_t w;
                w.sel  = bus.sel_o;
                w.addr = bus.addr_o;
                w.data = bus.wdata_o;
                act_q.push_back(w);
            end else if (bus.sel_o != '0) begin
                sel_glitches++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_dv_i   = 1'b1;
        bus.rx_byte_i = b;
        @(negedge clk_i);
        bus.rx_dv_i   = 1'b0;
    endtask

    task automatic fill_random(input int nbytes);
        payload.delete();
        for (int i = 0; i < nbytes; i++) payload.push_back(8'($urandom));
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_wr_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_sel"},  64'(act_q[i].sel),  64'(exp_q[i].sel));
            check({tag, "_addr"}, 64'(act_q[i].addr), 64'(exp_q[i].addr));
            check({tag, "_data"}, 64'(act_q[i].data), 64'(exp_q[i].data));
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_status(input string tag);
        check({tag, "_err"},   64'(bus.err_o),   64'(exp_err));
        check({tag, "_busy"},  64'(bus.busy_o),  64'd0);
        check({tag, "_reset"}, 64'(bus.reset_o), 64'd1);
    endtask

    // Section-level reference: a word is written iff all its bytes were sent and its index fits the memory.
    task automatic load_section(input string tag, input logic [7:0] hdr, input int n,
                                input int abort_at, input bit bad_chk);
        logic [7:0] stream[$];
        logic [7:0] csum;
        int total;
        csum = 8'h00;
        stream.push_back(hdr);
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        for (int i = 0; i < n * 4; i++) begin
            stream.push_back(payload[i]);
            csum ^= payload[i];
        end
        if (ChkEn) stream.push_back(bad_chk ? (csum ^ 8'h01) : csum);
        total = stream.size();

        for (int w = 0; w < n; w++) begin
            if (abort_at < 0 || (3 + 4 * w + 3) < abort_at) begin
                if (w < Depth) begin
                    wr_t e;
                    e.sel  = NumMems'(1) << hdr;
                    e.addr = AddrWidth'(w);
                    e.data = {payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]};
                    exp_q.push_back(e);
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        if (abort_at >= 0) exp_err = 1'b1;
        if (ChkEn && abort_at < 0 && bad_chk) exp_err = 1'b1;

        for (int i = 0; i < total; i++) begin
            if (i == abort_at) begin
                check({tag, "_busy_before_timeout"}, 64'(bus.busy_o), 64'd1);
                idle(TimeoutCycles + 30);
                break;
            end
            if (i > 0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            send_byte(stream[i]);
        end
        idle(3);
        compare_writes(tag);
        check_idle_status(tag);
    endtask

    task automatic enter_done(input string tag);
        bus.rx_dv_i   = 1'b1;
        bus.rx_byte_i = 8'hFF;
        check({tag, "_reset_at_ff"}, 64'(bus.reset_o), 64'd1);
        @(negedge clk_i);
        bus.rx_dv_i = 1'b0;
        check({tag, "_reset_after_ff"}, 64'(bus.reset_o), 64'd0);
        check({tag, "_busy_done"}, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic rearm(input string tag);
        send_byte(8'hFE);
        exp_err = 1'b0;
        idle(1);
        check_idle_status(tag);
    endtask

    initial begin
        bus.rx_dv_i   = 1'b0;
        bus.rx_byte_i = 8'h00;
        idle(3);
        check("rst_we",    64'(bus.we_o),    64'd0);
        check("rst_sel",   64'(bus.sel_o),   64'd0);
        check("rst_addr",  64'(bus.addr_o),  64'd0);
        check("rst_wdata", 64'(bus.wdata_o), 64'd0);
        check("rst_reset", 64'(bus.reset_o), 64'd1);
        check("rst_busy",  64'(bus.busy_o),  64'd0);
        check("rst_err",   64'(bus.err_o),   64'd0);
        rst_ni = 1'b1;
        idle(2);

        // Two words to memory 0, then finish loading.
        payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load_section("basic", 8'h00, 2, -1, 1'b0);
        enter_done("basic");
        check("basic_err_done", 64'(bus.err_o), 64'd0);
        rearm("rearm1");

        // Out-of-range header flags an error but does not block the next section.
        send_byte(8'h05);
        exp_err = 1'b1;
        idle(1);
        check("badhdr_err", 64'(bus.err_o), 64'd1);
        fill_random(8);
        load_section("mem1", 8'h01, 2, -1, 1'b0);

        // Overflow beyond the memory depth, then a fresh section still parses.
        fill_random(20);
        load_section("ovf", 8'h00, 5, -1, 1'b0);
        fill_random(4);
        load_section("after_ovf", 8'h01, 1, -1, 1'b0);
        enter_done("ovf");
        rearm("rearm2");

        // Inactivity timeout after two data bytes; partial word discarded.
        fill_random(4);
        load_section("tmo", 8'h00, 1, 5, 1'b0);
        fill_random(4);
        load_section("after_tmo", 8'h00, 1, -1, 1'b0);
        enter_done("tmo");
        rearm("rearm3");

        // Zero-length section returns straight to IDLE.
        payload.delete();
        load_section("zero_len", 8'h01, 0, -1, 1'b0);

        if (ChkEn) begin
            payload = '{8'h01, 8'h02, 8'h03, 8'h04};
            load_section("chk_good", 8'h00, 1, -1, 1'b0);
            load_section("chk_bad", 8'h00, 1, -1, 1'b1);
            enter_done("chk");
            rearm("rearm_chk");
        end

        // Power-on reset in the middle of a section.
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_ni = 1'b0;
        idle(1);
        check("midrst_busy",  64'(bus.busy_o),  64'd0);
        check("midrst_reset", 64'(bus.reset_o), 64'd1);
        check("midrst_err",   64'(bus.err_o),   64'd0);
        check("midrst_we",    64'(bus.we_o),    64'd0);
        rst_ni  = 1'b1;
        exp_err = 1'b0;
        act_q.delete();
        idle(1);
        fill_random(4);
        load_section("after_midrst", 8'h00, 1, -1, 1'b0);

        // Randomized mix of sections, bad headers, aborts and DONE/re-arm cycles.
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_byte(8'($urandom_range(2, 253)));
                exp_err = 1'b1;
                idle(1);
                check_idle_status("rnd_badhdr");
            end else if (r == 1) begin
                enter_done("rnd");
                send_byte(8'($urandom_range(0, 253)));
                check("rnd_done_junk_reset", 64'(bus.reset_o), 64'd0);
                check("rnd_done_junk_err",   64'(bus.err_o),   64'(exp_err));
                rearm("rnd_rearm");
            end else begin
                int n, total, abort_at;
                n = $urandom_range(0, 6);
                total = 3 + 4 * n + (ChkEn ? 1 : 0);
                abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, total - 1) : -1;
                fill_random(4 * n);
                load_section("rnd", 8'($urandom_range(0, NumMems - 1)), n, abort_at,
                             $urandom_range(0, 3) == 0);
            end
        end

        check("sel_idle_zero", 64'(sel_glitches), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
